// File: rtl/rf_black_widow_operand_issue_pkg.sv
// Shared types and sizes for the black widow operand issue stage.
package rf_black_widow_operand_issue_pkg;

  localparam int unsigned NREG   = 32;
  localparam int unsigned MAXFLY = 8;
  localparam int unsigned IR_W   = 40;
  localparam int unsigned IP_W   = 32;
  localparam int unsigned VAL_W  = 80;
  localparam int unsigned RN_W   = 5;
  localparam int unsigned FLY_W  = $clog2(MAXFLY + 1);

  typedef logic [IR_W-1:0]  instruction_t;
  typedef logic [IP_W-1:0]  address_t;
  typedef logic [VAL_W-1:0] value_t;
  typedef logic [RN_W-1:0]  regnum_t;

  // Operand bundle held in the output stage
  typedef struct packed {
    instruction_t ir;
    address_t     ip;
    value_t       a;
    value_t       b;
    value_t       c;
    value_t       imm;
    regnum_t      rt;
    logic         wr;
  } bundle_t;

  // True when a writeback this cycle targets a real (non-r0) register r
  function automatic logic wb_hits(input logic wb_valid, input regnum_t wb_rt, input regnum_t r);
    return wb_valid && (wb_rt == r) && (r != '0);
  endfunction

endpackage

// File: rtl/rf_black_widow_scoreboard.sv
// Busy-register scoreboard, in-flight write counter and issue hazard check.
module rf_black_widow_scoreboard
  import rf_black_widow_operand_issue_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  regnum_t ra,
  input  regnum_t rb,
  input  regnum_t rc,
  input  regnum_t rt,
  input  logic    wr,
  input  logic    issue,
  input  logic    wb_valid,
  input  regnum_t wb_rt,
  output logic    hazard_c,
  output logic    full_c
);

  logic [NREG-1:0]  busy_q, busy_d;
  logic [FLY_W-1:0] fly_q;
  logic             fly_inc, fly_dec;

  // A register still pending unless its result arrives this very cycle
  function automatic logic pending(input regnum_t r);
    return busy_q[r] && !wb_hits(wb_valid, wb_rt, r);
  endfunction

  // RAW on any source, or WAW on the destination
  always_comb begin
    hazard_c = pending(ra) || pending(rb) || pending(rc) || (wr && pending(rt));
    full_c   = wr && (fly_q == FLY_W'(MAXFLY));
  end

  // Next busy vector: writeback clears, a same-cycle issue to that register re-sets it
  always_comb begin
    busy_d = busy_q;
    if (wb_valid) busy_d[wb_rt] = 1'b0;
    if (issue && wr && (rt != '0)) busy_d[rt] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    fly_inc = issue && wr;
    fly_dec = wb_valid && (fly_q != '0);
  end

  // Scoreboard state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
      fly_q  <= '0;
    end else begin
      busy_q <= busy_d;
      if (fly_inc && !fly_dec)      fly_q <= fly_q + FLY_W'(1);
      else if (!fly_inc && fly_dec) fly_q <= fly_q - FLY_W'(1);
    end
  end

endmodule

// File: rtl/rf_black_widow_operand_issue.sv
// Decode-to-ALU operand issue: register file read with writeback bypass,
// scoreboard hazard stall, and a one-entry valid/ready output stage.
module rf_black_widow_operand_issue
  import rf_black_widow_operand_issue_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              dec_valid_i,
  output logic              dec_ready_o,
  input  logic [IR_W-1:0]   dec_ir_i,
  input  logic [IP_W-1:0]   dec_ip_i,
  input  logic [VAL_W-1:0]  dec_imm_i,
  input  logic [RN_W-1:0]   dec_ra_i,
  input  logic [RN_W-1:0]   dec_rb_i,
  input  logic [RN_W-1:0]   dec_rc_i,
  input  logic [RN_W-1:0]   dec_rt_i,
  input  logic              dec_wr_i,
  input  logic              flush_i,
  output logic              alu_valid_o,
  input  logic              alu_ready_i,
  output logic [IR_W-1:0]   alu_ir_o,
  output logic [IP_W-1:0]   alu_ip_o,
  output logic [VAL_W-1:0]  alu_a_o,
  output logic [VAL_W-1:0]  alu_b_o,
  output logic [VAL_W-1:0]  alu_c_o,
  output logic [VAL_W-1:0]  alu_imm_o,
  output logic [RN_W-1:0]   alu_rt_o,
  output logic              alu_wr_o,
  input  logic              wb_valid_i,
  input  logic [RN_W-1:0]   wb_rt_i,
  input  logic [VAL_W-1:0]  wb_res_i
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0] state_q, state_d;
  value_t     regs_q [NREG];
  bundle_t    bundle_q;
  logic       hazard_c, full_c;
  logic       issue, consume;
  value_t     opa, opb, opc;

  // Source read: r0 is zero, a same-cycle writeback wins over the file
  function automatic value_t read_op(input regnum_t r);
    if (r == '0) return '0;
    if (wb_hits(wb_valid_i, wb_rt_i, r)) return wb_res_i;
    return regs_q[r];
  endfunction

  rf_black_widow_scoreboard u_sb (
    .clk      (clk_i),
    .rst      (rst_i),
    .ra       (dec_ra_i),
    .rb       (dec_rb_i),
    .rc       (dec_rc_i),
    .rt       (dec_rt_i),
    .wr       (dec_wr_i),
    .issue    (issue),
    .wb_valid (wb_valid_i),
    .wb_rt    (wb_rt_i),
    .hazard_c (hazard_c),
    .full_c   (full_c)
  );

  // Handshakes and operand selection
  always_comb begin
    dec_ready_o = !flush_i && ((state_q == ST_EMPTY) || alu_ready_i) && !hazard_c && !full_c;
    issue       = dec_valid_i && dec_ready_o;
    consume     = alu_valid_o && alu_ready_i;
    opa         = read_op(dec_ra_i);
    opb         = read_op(dec_rb_i);
    opc         = read_op(dec_rc_i);
  end

  // Output stage next state; flush always empties the stage
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_EMPTY: if (issue) state_d = ST_FULL;
      ST_FULL:  if (!issue && consume) state_d = ST_EMPTY;
      default:  state_d = ST_EMPTY;
    endcase
    if (flush_i) state_d = ST_EMPTY;
  end

  // Output stage state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_EMPTY;
    else       state_q <= state_d;
  end

  // Bundle register loads only on issue, so it holds under backpressure
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bundle_q <= '0;
    end else if (issue) begin
      bundle_q.ir  <= dec_ir_i;
      bundle_q.ip  <= dec_ip_i;
      bundle_q.a   <= opa;
      bundle_q.b   <= opb;
      bundle_q.c   <= opc;
      bundle_q.imm <= dec_imm_i;
      bundle_q.rt  <= dec_rt_i;
      bundle_q.wr  <= dec_wr_i;
    end
  end

  // Register file; r0 is never written
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else if (wb_valid_i && (wb_rt_i != '0)) begin
      regs_q[wb_rt_i] <= wb_res_i;
    end
  end

  assign alu_valid_o = (state_q == ST_FULL);
  assign alu_ir_o    = bundle_q.ir;
  assign alu_ip_o    = bundle_q.ip;
  assign alu_a_o     = bundle_q.a;
  assign alu_b_o     = bundle_q.b;
  assign alu_c_o     = bundle_q.c;
  assign alu_imm_o   = bundle_q.imm;
  assign alu_rt_o    = bundle_q.rt;
  assign alu_wr_o    = bundle_q.wr;

endmodule

// File: tb/tb_rf_black_widow_operand_issue.sv
// Directed bench for the black widow operand issue stage.
module tb_rf_black_widow_operand_issue;
  import rf_black_widow_operand_issue_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         dec_valid_i, dec_ready_o, dec_wr_i, flush_i;
  logic [39:0]  dec_ir_i;
  logic [31:0]  dec_ip_i;
  logic [79:0]  dec_imm_i;
  logic [4:0]   dec_ra_i, dec_rb_i, dec_rc_i, dec_rt_i;
  logic         alu_valid_o, alu_ready_i, alu_wr_o;
  logic [39:0]  alu_ir_o;
  logic [31:0]  alu_ip_o;
  logic [79:0]  alu_a_o, alu_b_o, alu_c_o, alu_imm_o;
  logic [4:0]   alu_rt_o;
  logic         wb_valid_i;
  logic [4:0]   wb_rt_i;
  logic [79:0]  wb_res_i;

  rf_black_widow_operand_issue dut (
    .clk_i(clk), .rst_i(rst),
    .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o),
    .dec_ir_i(dec_ir_i), .dec_ip_i(dec_ip_i), .dec_imm_i(dec_imm_i),
    .dec_ra_i(dec_ra_i), .dec_rb_i(dec_rb_i), .dec_rc_i(dec_rc_i),
    .dec_rt_i(dec_rt_i), .dec_wr_i(dec_wr_i), .flush_i(flush_i),
    .alu_valid_o(alu_valid_o), .alu_ready_i(alu_ready_i),
    .alu_ir_o(alu_ir_o), .alu_ip_o(alu_ip_o), .alu_a_o(alu_a_o),
    .alu_b_o(alu_b_o), .alu_c_o(alu_c_o), .alu_imm_o(alu_imm_o),
    .alu_rt_o(alu_rt_o), .alu_wr_o(alu_wr_o),
    .wb_valid_i(wb_valid_i), .wb_rt_i(wb_rt_i), .wb_res_i(wb_res_i)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        dv;
    logic [4:0]  ra, rb, rc, rt;
    logic        wr;
    logic        wbv;
    logic [4:0]  wbrt;
    logic [79:0] wbres;
    logic        ardy, flush;
    logic        erdy, evld;
    logic [79:0] ea, eb, ec;
  } vec_t;

  int   checks = 0;
  int   errors = 0;
  vec_t tbl[$];

  function automatic vec_t mk(input int dv, input int ra, input int rb, input int rc,
                              input int rt, input int wr, input int wbv, input int wbrt,
                              input longint unsigned wbres, input int ardy, input int flush,
                              input int erdy, input int evld, input longint unsigned ea,
                              input longint unsigned eb, input longint unsigned ec);
    vec_t v;
    v.dv = 1'(dv); v.ra = 5'(ra); v.rb = 5'(rb); v.rc = 5'(rc); v.rt = 5'(rt);
    v.wr = 1'(wr); v.wbv = 1'(wbv); v.wbrt = 5'(wbrt); v.wbres = 80'(wbres);
    v.ardy = 1'(ardy); v.flush = 1'(flush); v.erdy = 1'(erdy); v.evld = 1'(evld);
    v.ea = 80'(ea); v.eb = 80'(eb); v.ec = 80'(ec);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called at a falling edge: drive, check ready, clock, check the stage
  task automatic apply(input vec_t v, input string nm);
    dec_valid_i = v.dv; dec_ra_i = v.ra; dec_rb_i = v.rb; dec_rc_i = v.rc;
    dec_rt_i = v.rt; dec_wr_i = v.wr; wb_valid_i = v.wbv; wb_rt_i = v.wbrt;
    wb_res_i = v.wbres; alu_ready_i = v.ardy; flush_i = v.flush;
    #1;
    chk($sformatf("%s dec_ready", nm), 80'(dec_ready_o), 80'(v.erdy));
    @(posedge clk);
    #1;
    chk($sformatf("%s alu_valid", nm), 80'(alu_valid_o), 80'(v.evld));
    if (v.evld) begin
      chk($sformatf("%s a", nm), alu_a_o, v.ea);
      chk($sformatf("%s b", nm), alu_b_o, v.eb);
      chk($sformatf("%s c", nm), alu_c_o, v.ec);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    dec_valid_i = 1'b0; dec_ir_i = 40'h12_3456_789A; dec_ip_i = 32'h1000;
    dec_imm_i = 80'h7; dec_ra_i = '0; dec_rb_i = '0; dec_rc_i = '0; dec_rt_i = '0;
    dec_wr_i = 1'b0; flush_i = 1'b0; alu_ready_i = 1'b1;
    wb_valid_i = 1'b0; wb_rt_i = '0; wb_res_i = '0;

    //            dv ra rb rc rt wr wbv wbrt wbres     ardy fl erdy evld ea     eb     ec
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,          1, 0, 1, 0, 0,     0,     0));
    tbl.push_back(mk(1, 0, 0, 0, 3, 1, 0, 0, 0,          1, 0, 1, 1, 0,     0,     0));
    tbl.push_back(mk(1, 3, 3, 0, 4, 1, 1, 3, 7,          1, 0, 1, 1, 7,     7,     0));
    tbl.push_back(mk(1, 4, 3, 0, 5, 1, 0, 0, 0,          1, 0, 0, 0, 0,     0,     0));
    tbl.push_back(mk(1, 4, 3, 0, 5, 1, 0, 0, 0,          1, 0, 0, 0, 0,     0,     0));
    tbl.push_back(mk(1, 4, 3, 0, 5, 1, 0, 0, 0,          1, 0, 0, 0, 0,     0,     0));
    tbl.push_back(mk(1, 4, 3, 0, 5, 1, 1, 4, 100,        1, 0, 1, 1, 100,   7,     0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 5, 'h55,       1, 0, 1, 0, 0,     0,     0));
    tbl.push_back(mk(1, 3, 4, 0, 6, 0, 0, 0, 0,          0, 0, 1, 1, 7,     100,   0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1, 5, 5, 5, 0, 0, 0, 0, 0,        0, 0, 0, 1, 7,     100,   0));
    tbl.push_back(mk(1, 5, 5, 5, 0, 0, 0, 0, 0,          1, 0, 1, 1, 'h55,  'h55,  'h55));
    tbl.push_back(mk(1, 4, 3, 0, 0, 0, 0, 0, 0,          1, 0, 1, 1, 100,   7,     0));
    tbl.push_back(mk(1, 3, 5, 0, 0, 0, 0, 0, 0,          1, 0, 1, 1, 7,     'h55,  0));
    tbl.push_back(mk(1, 0, 4, 0, 0, 0, 0, 0, 0,          1, 0, 1, 1, 0,     100,   0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,          1, 0, 1, 0, 0,     0,     0));
    tbl.push_back(mk(1, 3, 0, 0, 7, 1, 0, 0, 0,          0, 0, 1, 1, 7,     0,     0));
    tbl.push_back(mk(1, 3, 0, 0, 8, 0, 0, 0, 0,          0, 1, 0, 0, 0,     0,     0));
    tbl.push_back(mk(1, 7, 0, 0, 0, 0, 0, 0, 0,          1, 0, 0, 0, 0,     0,     0));
    tbl.push_back(mk(1, 7, 0, 0, 0, 0, 1, 7, 'h99,       1, 0, 1, 1, 'h99,  0,     0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,          1, 0, 1, 0, 0,     0,     0));
    tbl.push_back(mk(1, 0, 7, 0, 0, 0, 1, 0, 'hdead,     1, 0, 1, 1, 0,     'h99,  0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,          1, 0, 1, 0, 0,     0,     0));
    tbl.push_back(mk(1, 0, 0, 0, 3, 1, 0, 0, 0,          1, 0, 1, 1, 0,     0,     0));
    tbl.push_back(mk(1, 0, 0, 0, 3, 1, 0, 0, 0,          1, 0, 0, 0, 0,     0,     0));
    tbl.push_back(mk(1, 0, 0, 0, 3, 1, 1, 3, 'h11,       1, 0, 1, 1, 0,     0,     0));
    tbl.push_back(mk(1, 3, 0, 0, 0, 0, 0, 0, 0,          1, 0, 0, 0, 0,     0,     0));
    tbl.push_back(mk(1, 3, 0, 0, 0, 0, 1, 3, 'h22,       1, 0, 1, 1, 'h22,  0,     0));

    repeat (2) @(negedge clk);
    chk("reset alu_valid", 80'(alu_valid_o), 80'(0));
    chk("reset alu_ir", 80'(alu_ir_o), 80'(0));
    rst = 1'b0;

    foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

    // Fill all in-flight slots, then the ninth writer waits for a writeback
    for (int i = 1; i <= 8; i++)
      apply(mk(1, 0, 0, 0, i, 1, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0), $sformatf("fly%0d", i));
    apply(mk(1, 0, 0, 0, 9, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), "fly9 stall a");
    apply(mk(1, 0, 0, 0, 9, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0), "fly9 stall b");
    apply(mk(1, 0, 0, 0, 9, 1, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0), "fly9 wb cycle");
    apply(mk(1, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0), "fly9 issue");

    // Asynchronous reset while the stage is full
    chk("pre-reset alu_rt", 80'(alu_rt_o), 80'(9));
    #2 rst = 1'b1;
    #1;
    chk("mid reset alu_valid", 80'(alu_valid_o), 80'(0));
    chk("mid reset alu_rt", 80'(alu_rt_o), 80'(0));
    @(negedge clk);
    rst = 1'b0;
    apply(mk(1, 5, 1, 0, 1, 1, 0, 0, 0, 1, 0, 1, 1, 0, 0, 0), "post reset read");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Hard stop if the sequence ever stalls outright
  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
